// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types, lane geometry and rate table for the Keccak sponge controller
package keccak_pkg;

  localparam int LANE_W     = 64;
  localparam int NUM_LANES  = 1600 / LANE_W;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);

  typedef enum logic [2:0] {
    MODE_SHA3_224 = 3'd0,
    MODE_SHA3_256 = 3'd1,
    MODE_SHA3_384 = 3'd2,
    MODE_SHA3_512 = 3'd3,
    MODE_SHAKE128 = 3'd4,
    MODE_SHAKE256 = 3'd5
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ABSORB  = 3'd2,
    ST_PERMUTE = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Rate in 64-bit lanes; unsupported encodings return 0 and are never latched.
  function automatic logic [LANE_IDX_W-1:0] rate_lanes(input mode_e m);
    case (m)
      MODE_SHA3_224: rate_lanes = LANE_IDX_W'(18);
      MODE_SHA3_256: rate_lanes = LANE_IDX_W'(17);
      MODE_SHA3_384: rate_lanes = LANE_IDX_W'(13);
      MODE_SHA3_512: rate_lanes = LANE_IDX_W'(9);
      MODE_SHAKE128: rate_lanes = LANE_IDX_W'(21);
      MODE_SHAKE256: rate_lanes = LANE_IDX_W'(17);
      default:       rate_lanes = '0;
    endcase
  endfunction

endpackage

// File: rtl/keccak_round_ctr.sv
// rtl/keccak_round_ctr.sv - permutation round counter with configurable rounds per cycle
module keccak_round_ctr #(
  parameter int NUM_ROUNDS       = 24,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic       last_cyc,
  output logic [4:0] round_idx
);

  if (ROUNDS_PER_CYCLE < 1 || (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_cfg_check
    $error("ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  localparam int NUM_CYC = NUM_ROUNDS / ROUNDS_PER_CYCLE;

  logic [4:0] round_cnt_q, round_cnt_d;

  assign last_cyc  = (round_cnt_q == 5'(NUM_CYC - 1));
  assign round_idx = 5'(round_cnt_q * ROUNDS_PER_CYCLE);

  // Advance one step per enabled cycle, wrapping to 0 after the final step.
  always_comb begin
    round_cnt_d = round_cnt_q;
    if (clr) begin
      round_cnt_d = '0;
    end else if (en) begin
      round_cnt_d = last_cyc ? 5'd0 : round_cnt_q + 5'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt_q <= '0;
    end else begin
      round_cnt_q <= round_cnt_d;
    end
  end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// rtl/keccak_sponge_ctrl.sv - sponge sequencer: clear, absorb, permute and multi-block squeeze
module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS       = 24,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int OUT_CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [OUT_CNT_W-1:0] out_lanes,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 state_clr,
  output logic                 absorb_en,
  output logic [4:0]           lane_idx,
  output logic                 perm_en,
  output logic [4:0]           round_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e                 state_q, state_d;
  logic [LANE_IDX_W-1:0]  rate_q, rate_d;
  logic [LANE_IDX_W-1:0]  lane_cnt_q, lane_cnt_d;
  logic [OUT_CNT_W-1:0]   remaining_q, remaining_d;
  logic                   last_blk_q, last_blk_d;
  logic                   squeeze_q, squeeze_d;
  logic                   err_q, err_d;

  logic                   perm_last;
  logic [4:0]             ctr_round_idx;
  logic                   start_ok;
  logic                   lane_at_rate_end;

  keccak_round_ctr #(
    .NUM_ROUNDS       (NUM_ROUNDS),
    .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE)
  ) u_round_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == ST_PERMUTE),
    .clr       (state_q == ST_CLEAR),
    .last_cyc  (perm_last),
    .round_idx (ctr_round_idx)
  );

  assign start_ok         = start && (out_lanes != '0) && (mode <= 3'd5);
  assign lane_at_rate_end = (lane_cnt_q == rate_q - LANE_IDX_W'(1));

  // Next-state and bookkeeping for the sponge sequence.
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    lane_cnt_d  = lane_cnt_q;
    remaining_d = remaining_q;
    last_blk_d  = last_blk_q;
    squeeze_d   = squeeze_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          rate_d      = rate_lanes(mode_e'(mode));
          remaining_d = out_lanes;
          last_blk_d  = 1'b0;
          squeeze_d   = 1'b0;
          err_d       = 1'b0;
          state_d     = ST_CLEAR;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        lane_cnt_d = '0;
        state_d    = ST_ABSORB;
      end
      ST_ABSORB: begin
        if (in_valid) begin
          lane_cnt_d = lane_cnt_q + LANE_IDX_W'(1);
          if (lane_at_rate_end || in_last) begin
            // A short final block leaves the tail lanes as zero in the state.
            last_blk_d = in_last;
            if (!lane_at_rate_end) begin
              err_d = 1'b1;
            end
            state_d = ST_PERMUTE;
          end
        end
      end
      ST_PERMUTE: begin
        if (perm_last) begin
          lane_cnt_d = '0;
          if (last_blk_q || squeeze_q) begin
            squeeze_d = 1'b1;
            state_d   = ST_SQUEEZE;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end
      ST_SQUEEZE: begin
        if (out_ready) begin
          remaining_d = remaining_q - OUT_CNT_W'(1);
          lane_cnt_d  = lane_cnt_q + LANE_IDX_W'(1);
          if (remaining_q == OUT_CNT_W'(1)) begin
            state_d = ST_DONE;
          end else if (lane_at_rate_end) begin
            state_d = ST_PERMUTE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rate_q      <= '0;
      lane_cnt_q  <= '0;
      remaining_q <= '0;
      last_blk_q  <= 1'b0;
      squeeze_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      lane_cnt_q  <= lane_cnt_d;
      remaining_q <= remaining_d;
      last_blk_q  <= last_blk_d;
      squeeze_q   <= squeeze_d;
      err_q       <= err_d;
    end
  end

  // Moore decode of the registered state; absorb_en alone is qualified by in_valid.
  always_comb begin
    in_ready  = (state_q == ST_ABSORB);
    absorb_en = (state_q == ST_ABSORB) && in_valid;
    out_valid = (state_q == ST_SQUEEZE);
    state_clr = (state_q == ST_CLEAR);
    perm_en   = (state_q == ST_PERMUTE);
    lane_idx  = ((state_q == ST_ABSORB) || (state_q == ST_SQUEEZE)) ? 5'(lane_cnt_q) : 5'd0;
    round_idx = (state_q == ST_PERMUTE) ? ctr_round_idx : 5'd0;
    busy      = (state_q == ST_CLEAR) || (state_q == ST_ABSORB) ||
                (state_q == ST_PERMUTE) || (state_q == ST_SQUEEZE);
    done      = (state_q == ST_DONE);
    err       = err_q;
  end

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
- Parametrised sponge controller for the Keccak core; successor to the fixed single-mode absorb/permute control FSM.
- Accepts padded message lanes over a valid/ready stream and sequences absorb, permute and squeeze.
- Supports six SHA-3/SHAKE modes, configurable round unrolling, and multi-block squeeze for XOF output.
- Sits between the lane input buffer and the permutation datapath. It drives lane and round indices plus enables; the datapath holds the 1600-bit state.

Parameters:
- NUM_ROUNDS, 24, Keccak-f rounds per permutation.
- ROUNDS_PER_CYCLE, 1, rounds the datapath executes per perm_en cycle. Must divide NUM_ROUNDS; elaboration error otherwise.
- OUT_CNT_W, 16, width of the requested output-lane count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk.
- start  in  1  begin a new hash. Honoured only in IDLE/DONE.
- mode  in  3  0=SHA3-224 (rate 18 lanes), 1=SHA3-256 (17), 2=SHA3-384 (13), 3=SHA3-512 (9), 4=SHAKE128 (21), 5=SHAKE256 (17). Latched at start.
- out_lanes  in  OUT_CNT_W  number of 64-bit output lanes to squeeze. Latched at start.
- in_valid  in  1  input lane valid.
- in_last  in  1  current lane is the final lane of the padded message.
- in_ready  out  1  controller accepts an input lane.
- out_valid  out  1  state lane lane_idx is presented as output.
- out_ready  in  1  sink accepts output lane.
- state_clr  out  1  datapath zeroes state this cycle.
- absorb_en  out  1  datapath XORs input lane into lane lane_idx this cycle.
- lane_idx  out  5  lane index for absorb/squeeze.
- perm_en  out  1  datapath applies rounds round_idx .. round_idx+ROUNDS_PER_CYCLE-1.
- round_idx  out  5  first round of this perm cycle.
- busy  out  1  high in CLEAR/ABSORB/PERMUTE/SQUEEZE.
- done  out  1  high in DONE.
- err  out  1  sticky protocol error; cleared on accepted start.

Behaviour:
- Reset: state IDLE; all outputs 0; counters, latched mode/out_lanes and err are 0.
- States: IDLE, CLEAR, ABSORB, PERMUTE, SQUEEZE, DONE. Registered state; Moore outputs, except handshake-qualified absorb_en.
- IDLE/DONE:
  - start with out_lanes != 0: latch mode, out_lanes, rate; clear err; go to CLEAR.
  - start with out_lanes == 0 or mode > 5: set err; stay in place.
  - done is held in DONE until start is accepted.
- CLEAR (1 cycle): state_clr=1; lane_cnt=0; go to ABSORB.
- ABSORB:
  - in_ready=1; absorb_en=in_valid; lane_idx=lane_cnt.
  - Per handshake, lane_cnt increments.
  - Handshake with lane_cnt==rate-1 or in_last: go to PERMUTE; last_blk=in_last.
  - in_last with lane_cnt<rate-1: set err; the remaining lanes count as zero (no absorb); permute proceeds.
- PERMUTE:
  - perm_en=1; round_idx=round_cnt*ROUNDS_PER_CYCLE.
  - Lasts NUM_ROUNDS/ROUNDS_PER_CYCLE cycles.
  - On the final cycle: round_cnt=0, lane_cnt=0. Next state is SQUEEZE if last_blk or squeeze_phase, else ABSORB.
  - in_ready=0 throughout.
- SQUEEZE:
  - out_valid=1; lane_idx=lane_cnt; squeeze_phase=1.
  - Per handshake: remaining decrements, lane_cnt increments.
  - remaining==1 at handshake: go to DONE.
  - Else lane_cnt==rate-1 at handshake: go to PERMUTE; return here afterwards.
  - out_valid must not drop without a handshake.
- Latency, SHA3-256, one block, no stalls:
  - start at cycle 0; CLEAR at 1; absorb at 2..18; PERMUTE at 19..42.
  - out_valid from 43; done at 43+out_lanes.
- start while busy: ignored; no err.
- rst_n mid-operation: immediate return to IDLE; outputs 0; no residual err.

Decomposition:
- keccak_pkg holds:
  - mode_e enum;
  - function rate_lanes(mode_e) returning 5-bit lane count;
  - state_e enum;
  - LANE_W=64.
- Sub-module keccak_round_ctr: round counter with en, clr, last_cyc output and round_idx, parametrised by NUM_ROUNDS and ROUNDS_PER_CYCLE.

Test Plan:
- SHA3-256, out_lanes=4, continuous valid/ready, 17 lanes, in_last on lane 16 -> state_clr at cycle 1; 17 absorb_en beats with lane_idx 0..16; perm_en 24 cycles with round_idx 0..23; 4 out beats with lane_idx 0..3; done at cycle 47; err=0.
- SHA3-512, two blocks of 9 lanes with in_valid gaps -> two 24-cycle permutes; in_ready=0 during each; squeeze follows the second permute.
- SHAKE128, out_lanes=25 -> 21 out beats with lane_idx 0..20; then a 24-cycle permute; then 4 beats with lane_idx 0..3; then done.
- SHA3-256 with in_last on lane 5 -> err=1; PERMUTE entered immediately after; squeeze completes normally.
- ROUNDS_PER_CYCLE=2 -> 12 perm cycles with round_idx 0,2,..,22. Random out_ready backpressure -> lane order preserved, no lane dropped or duplicated.
- rst_n asserted at round 10 -> all outputs 0 and IDLE next edge. start with out_lanes=0 -> err=1, busy stays 0.
